nor_seq_ctrl: RTL

//  Multi-cycle sequencer that time-shares one n-bit nor_par array to evaluate
//  NOR, NOT, OR, AND, NAND, XNOR and XOR using NOR-only micro-steps.

---
 rtl/nor_seq_ctrl_pkg.sv | 77 +++++++
 rtl/nor_seq_ctrl_if.sv | 18 +
 rtl/nor_seq_ctrl_nor_par.sv | 12 +
 rtl/nor_seq_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/nor_seq_ctrl_pkg.sv
// Shared definitions for the NOR-only sequencer: op codes, operand-select and
// destination codes, per-op step counts and the micro-step decode table.
package nor_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    OpNor  = 3'b000,
    OpNot  = 3'b001,
    OpOr   = 3'b010,
    OpAnd  = 3'b011,
    OpNand = 3'b100,
    OpXnor = 3'b101,
    OpXor  = 3'b110,
    OpIll  = 3'b111
  } op_e;

  typedef enum logic [2:0] {SelA, SelB, SelT1, SelT2, SelT3, SelR} sel_e;

  typedef enum logic [1:0] {DstT1, DstT2, DstT3, DstR} dst_e;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  typedef struct packed {
    sel_e selx;
    sel_e sely;
    dst_e dst;
    logic last;
  } ustep_t;

  function automatic logic [2:0] step_count(op_e op);
    case (op)
      OpOr:           return 3'd2;
      OpAnd:          return 3'd3;
      OpNand, OpXnor: return 3'd4;
      OpXor:          return 3'd5;
      default:        return 3'd1;
    endcase
  endfunction

  function automatic ustep_t mk_step(sel_e x, sel_e y, dst_e d);
    ustep_t s;
    s.selx = x;
    s.sely = y;
    s.dst  = d;
    s.last = 1'b0;
    return s;
  endfunction

  // NAND and XOR reuse the AND / XNOR sequence and add a final R=NOR(R,R).
  function automatic ustep_t micro_step(op_e op, logic [2:0] step);
    ustep_t s;
    case (op)
      OpNor: s = mk_step(SelA, SelB, DstR);
      OpOr:  s = (step == 3'd0) ? mk_step(SelA, SelB, DstT1) : mk_step(SelT1, SelT1, DstR);
      OpAnd, OpNand: begin
        case (step)
          3'd0:    s = mk_step(SelA, SelA, DstT1);
          3'd1:    s = mk_step(SelB, SelB, DstT2);
          3'd2:    s = mk_step(SelT1, SelT2, DstR);
          default: s = mk_step(SelR, SelR, DstR);
        endcase
      end
      OpXnor, OpXor: begin
        case (step)
          3'd0:    s = mk_step(SelA, SelB, DstT1);
          3'd1:    s = mk_step(SelA, SelT1, DstT2);
          3'd2:    s = mk_step(SelB, SelT1, DstT3);
          3'd3:    s = mk_step(SelT2, SelT3, DstR);
          default: s = mk_step(SelR, SelR, DstR);
        endcase
      end
      default: s = mk_step(SelA, SelA, DstR);  // NOT and illegal
    endcase
    s.last = (step == step_count(op) - 3'd1);
    return s;
  endfunction

endpackage

// File: rtl/nor_seq_ctrl_if.sv
// Handshake between the control unit (master) and the sequencer (slave).
//   start/op/a/b : request and operands, sampled when the sequencer is idle
//   busy/done/err/result : status and final value
interface nor_seq_ctrl_if #(
  parameter int unsigned N = 4
) ();
  logic         start;
  logic [2:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic         err;
  logic [N-1:0] result;

  modport master (output start, op, a, b, input busy, done, err, result);
  modport slave  (input start, op, a, b, output busy, done, err, result);
endinterface

// File: rtl/nor_seq_ctrl_nor_par.sv
// Shared n-bit bitwise NOR array.
//   a_i, b_i : operands
//   y_o      : ~(a_i | b_i)
module nor_par #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] y_o
);
  assign y_o = ~(a_i | b_i);
endmodule

// File: rtl/nor_seq_ctrl.sv
// Multi-cycle sequencer that evaluates NOR/NOT/OR/AND/NAND/XNOR/XOR by
// time-sharing one nor_par array, one NOR evaluation per clock.
//   clk_i : clock, all state on posedge
//   rst_i : synchronous active-high reset
//   bus   : slave side of nor_seq_ctrl_if (start/op/a/b in; busy/done/err/result out)
module nor_seq_ctrl #(
  parameter int unsigned N = 4
) (
  input logic          clk_i,
  input logic          rst_i,
  nor_seq_ctrl_if.slave bus
);
  import nor_seq_ctrl_pkg::*;

  state_e       state_q, state_d;
  logic [2:0]   step_q, step_d;
  op_e          op_q, op_d;
  logic [N-1:0] a_q, a_d, b_q, b_d;
  logic [N-1:0] t1_q, t1_d, t2_q, t2_d, t3_q, t3_d, r_q, r_d;
  logic [N-1:0] result_q, result_d;
  logic         done_q, done_d, err_q, err_d;

  ustep_t       ms;
  logic [N-1:0] x, y, nor_y, wr_val;

  assign ms = micro_step(op_q, step_q);

  always_comb begin
    x = a_q;
    case (ms.selx)
      SelA:    x = a_q;
      SelB:    x = b_q;
      SelT1:   x = t1_q;
      SelT2:   x = t2_q;
      SelT3:   x = t3_q;
      SelR:    x = r_q;
      default: x = a_q;
    endcase
  end

  always_comb begin
    y = a_q;
    case (ms.sely)
      SelA:    y = a_q;
      SelB:    y = b_q;
      SelT1:   y = t1_q;
      SelT2:   y = t2_q;
      SelT3:   y = t3_q;
      SelR:    y = r_q;
      default: y = a_q;
    endcase
  end

  nor_par #(.N(N)) u_nor_par (
    .a_i (x),
    .b_i (y),
    .y_o (nor_y)
  );

  // Illegal op still takes one step but forces a zero result.
  assign wr_val = (op_q == OpIll) ? '0 : nor_y;

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    t1_d     = t1_q;
    t2_d     = t2_q;
    t3_d     = t3_q;
    r_d      = r_q;
    result_d = result_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRun;
          step_d  = 3'd0;
          op_d    = op_e'(bus.op);
          a_d     = bus.a;
          b_d     = bus.b;
        end
      end
      StRun: begin
        case (ms.dst)
          DstT1:   t1_d = wr_val;
          DstT2:   t2_d = wr_val;
          DstT3:   t3_d = wr_val;
          default: r_d  = wr_val;
        endcase
        step_d = step_q + 3'd1;
        if (ms.last) begin
          state_d  = StIdle;
          result_d = wr_val;
          done_d   = 1'b1;
          err_d    = (op_q == OpIll);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      step_q   <= 3'd0;
      op_q     <= OpNor;
      a_q      <= '0;
      b_q      <= '0;
      t1_q     <= '0;
      t2_q     <= '0;
      t3_q     <= '0;
      r_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      t1_q     <= t1_d;
      t2_q     <= t2_d;
      t3_q     <= t3_d;
      r_q      <= r_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.busy   = (state_q == StRun);
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;

endmodule
